// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: PC generation, in-order memory requests and a small
// fetch queue feeding decode, with redirect flush and stale-response dropping.
module pc_fetch_unit #(
   parameter int                         INST_WIDTH      = 32,
   parameter int                         INST_ADDR_WIDTH = 32,
   parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0,
   parameter int                         PC_STEP         = 4,
   parameter int                         FQ_DEPTH        = 4
) (
   input  logic                       cpu_clk,
   input  logic                       cpu_rst_n,
   input  logic                       redirect_valid,
   input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
   output logic                       imem_req_valid,
   output logic [INST_ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                       imem_req_ready,
   input  logic                       imem_rsp_valid,
   input  logic [INST_WIDTH-1:0]      imem_rsp_inst,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INST_ADDR_WIDTH-1:0] out_pc,
   output logic [INST_WIDTH-1:0]      out_inst
);

   localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;

   logic [INST_ADDR_WIDTH-1:0] fetch_pc;
   logic [INST_ADDR_WIDTH-1:0] pc_q   [FQ_DEPTH];
   logic [INST_WIDTH-1:0]      inst_q [FQ_DEPTH];
   logic [FQ_DEPTH-1:0]        filled;
   logic [FQ_DEPTH-1:0]        filled_next;
   ptr_t                       head;
   ptr_t                       tail;
   ptr_t                       fill_ptr;
   cnt_t                       count;
   cnt_t                       pend_cnt;
   cnt_t                       drop_cnt;

   logic [CNT_W:0]             occupancy;
   logic [CNT_W:0]             stale_sum;
   logic [CNT_W:0]             redirect_drop;
   logic                       req_fire;
   logic                       pop;
   logic                       rsp_drop;
   logic                       rsp_fill;

   // Outstanding stale responses still occupy queue slots so memory can never run ahead.
   assign occupancy      = {1'b0, count} + {1'b0, drop_cnt};
   assign imem_req_valid = cpu_rst_n && !redirect_valid
                           && (occupancy < (CNT_W+1)'(FQ_DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign out_valid = filled[head] && !redirect_valid;
   assign out_pc    = pc_q[head];
   assign out_inst  = inst_q[head];
   assign pop       = out_valid && out_ready;

   assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
   assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && (pend_cnt != '0);

   always_comb begin
      stale_sum = {1'b0, drop_cnt} + {1'b0, pend_cnt};
      redirect_drop = stale_sum;
      if (imem_rsp_valid && (stale_sum != '0)) begin
         redirect_drop = stale_sum - (CNT_W+1)'(1);
      end
   end

   always_comb begin
      filled_next = filled;
      if (pop) begin
         filled_next[head] = 1'b0;
      end
      if (rsp_fill) begin
         filled_next[fill_ptr] = 1'b1;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         fill_ptr <= '0;
         count    <= '0;
         pend_cnt <= '0;
         drop_cnt <= '0;
         filled   <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
         head     <= '0;
         tail     <= '0;
         fill_ptr <= '0;
         count    <= '0;
         pend_cnt <= '0;
         drop_cnt <= cnt_t'(redirect_drop);
         filled   <= '0;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + INST_ADDR_WIDTH'(PC_STEP);
            tail     <= tail + ptr_t'(1);
         end
         if (pop) begin
            head <= head + ptr_t'(1);
         end
         if (rsp_fill) begin
            fill_ptr <= fill_ptr + ptr_t'(1);
         end
         if (rsp_drop) begin
            drop_cnt <= drop_cnt - cnt_t'(1);
         end
         count    <= count + cnt_t'(req_fire) - cnt_t'(pop);
         pend_cnt <= pend_cnt + cnt_t'(req_fire) - cnt_t'(rsp_fill);
         filled   <= filled_next;
      end
   end

   // Payload storage needs no reset; the filled bits alone decide validity.
   always_ff @(posedge cpu_clk) begin
      if (req_fire) begin
         pc_q[tail] <= fetch_pc;
      end
      if (rsp_fill && !redirect_valid) begin
         inst_q[fill_ptr] <= imem_rsp_inst;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a cycle-by-cycle vector table from reset plus
// short hand-written sequences for redirect, wrap-around and mid-stream reset.
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        redir;
      logic [31:0] rpc;
      logic        rready;
      logic        rsp;
      logic [31:0] inst;
      logic        ordy;
      logic        exp_rv;
      logic [31:0] exp_addr;
      logic        exp_ov;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
   } vec_t;

   vec_t vecs [13];

   pc_fetch_unit dut (
      .cpu_clk        (clk),
      .cpu_rst_n      (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_inst  (imem_rsp_inst),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_stimulus(input logic redir, input logic [31:0] rpc, input logic rready,
                                 input logic rsp, input logic [31:0] inst, input logic ordy);
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_req_ready = rready;
      imem_rsp_valid = rsp;
      imem_rsp_inst  = inst;
      out_ready      = ordy;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00,  1'b0, 32'h0,   32'h0};
      vecs[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h1111_0000, 1'b1, 1'b1, 32'h04,  1'b0, 32'h0,   32'h0};
      vecs[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h1111_0004, 1'b1, 1'b1, 32'h08,  1'b1, 32'h0,   32'h1111_0000};
      vecs[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h1111_0008, 1'b1, 1'b1, 32'h0C,  1'b1, 32'h4,   32'h1111_0004};
      vecs[4]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h1111_000C, 1'b0, 1'b1, 32'h10,  1'b1, 32'h8,   32'h1111_0008};
      vecs[5]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10,  1'b1, 32'h8,   32'h1111_0008};
      vecs[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h1111_0010, 1'b0, 1'b1, 32'h14,  1'b1, 32'h8,   32'h1111_0008};
      vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h18,  1'b1, 32'h8,   32'h1111_0008};
      vecs[8]  = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h18,  1'b0, 32'h0,   32'h0};
      vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hDEAD_0014, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
      vecs[10] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h1111_0100, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   32'h0};
      vecs[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h104, 1'b1, 32'h100, 32'h1111_0100};
      vecs[12] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   32'h0};

      // Reset state, with memory ready and a response arriving during reset.
      rst_n = 1'b0;
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hBEEF_0000, 1'b1);
      @(negedge clk);
      #1;
      check_output("reset_req_valid", 32'(imem_req_valid), 32'h0);
      check_output("reset_out_valid", 32'(out_valid), 32'h0);
      check_output("reset_drop_cnt", 32'(dut.drop_cnt), 32'h0);

      // Streaming, back-pressure to a full queue, then redirect with one in flight.
      do_reset();
      for (int i = 0; i < 13; i++) begin
         apply_stimulus(vecs[i].redir, vecs[i].rpc, vecs[i].rready, vecs[i].rsp, vecs[i].inst, vecs[i].ordy);
         #1;
         check_output($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_rv));
         check_output($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
         check_output($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         if (vecs[i].exp_ov) begin
            check_output($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].exp_pc);
            check_output($sformatf("vec%0d_out_inst", i), out_inst, vecs[i].exp_inst);
         end
         step();
      end

      // Redirect with three requests in flight: all three responses are dropped.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
         step();
      end
      apply_stimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1);
      #1;
      check_output("r3_req_valid_in_redirect", 32'(imem_req_valid), 32'h0);
      step();
      check_output("r3_drop_cnt", 32'(dut.drop_cnt), 32'h3);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0000 + 32'(i), 1'b1);
         #1;
         check_output($sformatf("r3_req_addr_%0d", i), imem_req_addr, 32'h100);
         step();
         check_output($sformatf("r3_drop_dec_%0d", i), 32'(dut.drop_cnt), 32'(2 - i));
         check_output($sformatf("r3_out_valid_%0d", i), 32'(out_valid), 32'h0);
      end
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      #1;
      check_output("r3_new_req_valid", 32'(imem_req_valid), 32'h1);
      step();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0100, 1'b1);
      step();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      #1;
      check_output("r3_out_valid", 32'(out_valid), 32'h1);
      check_output("r3_out_pc", out_pc, 32'h100);
      check_output("r3_out_inst", out_inst, 32'hCAFE_0100);

      // Redirect coinciding with a response: that response is stale.
      do_reset();
      for (int i = 0; i < 2; i++) begin
         apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
         step();
      end
      apply_stimulus(1'b1, 32'h200, 1'b1, 1'b1, 32'hBAD0_0000, 1'b1);
      #1;
      check_output("rr_out_valid_in_redirect", 32'(out_valid), 32'h0);
      step();
      check_output("rr_drop_cnt", 32'(dut.drop_cnt), 32'h1);
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0004, 1'b1);
      step();
      check_output("rr_drop_zero", 32'(dut.drop_cnt), 32'h0);
      check_output("rr_stale_not_delivered", 32'(out_valid), 32'h0);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      #1;
      check_output("rr_req_addr", imem_req_addr, 32'h200);
      step();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_0200, 1'b1);
      step();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      #1;
      check_output("rr_out_pc", out_pc, 32'h200);
      check_output("rr_out_inst", out_inst, 32'h2222_0200);

      // PC wrap-around at the top of the address space.
      do_reset();
      apply_stimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1);
      step();
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      #1;
      check_output("wrap_req_valid", 32'(imem_req_valid), 32'h1);
      check_output("wrap_req_addr_top", imem_req_addr, 32'hFFFF_FFFC);
      step();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h3333_0000, 1'b1);
      #1;
      check_output("wrap_req_addr_zero", imem_req_addr, 32'h0);
      step();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      #1;
      check_output("wrap_out_pc", out_pc, 32'hFFFF_FFFC);

      // Reset asserted mid-stream with two filled entries.
      do_reset();
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h4444_0000, 1'b0);
      step();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h4444_0004, 1'b0);
      step();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      check_output("mid_out_valid_before", 32'(out_valid), 32'h1);
      check_output("mid_out_pc_before", out_pc, 32'h0);
      #2;
      rst_n = 1'b0;
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h5555_0000, 1'b1);
      #1;
      check_output("mid_out_valid_in_reset", 32'(out_valid), 32'h0);
      check_output("mid_req_valid_in_reset", 32'(imem_req_valid), 32'h0);
      repeat (2) @(negedge clk);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      rst_n = 1'b1;
      #1;
      check_output("mid_req_valid_after", 32'(imem_req_valid), 32'h1);
      check_output("mid_req_addr_after", imem_req_addr, 32'h0);
      step();
      check_output("mid_out_valid_after", 32'(out_valid), 32'h0);
      check_output("mid_req_addr_next", imem_req_addr, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter INST_ADDR_WIDTH, default 32, PC width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have parameter PC_STEP, default 4, sequential PC increment.
REQ-005 SHALL have parameter FQ_DEPTH, default 4, fetch-queue entries; power of two, >=2.
REQ-006 SHALL have port cpu_clk, input, 1, single clock; all state on its rising edge.
REQ-007 SHALL have port cpu_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port redirect_valid, input, 1, branch/jump/trap redirect request.
REQ-009 SHALL have port redirect_pc, input, INST_ADDR_WIDTH, redirect target.
REQ-010 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-011 SHALL have port imem_req_addr, output, INST_ADDR_WIDTH, fetch address (equals fetch_pc).
REQ-012 SHALL have port imem_req_ready, input, 1, memory accepts request.
REQ-013 SHALL have port imem_rsp_valid, input, 1, in-order response valid.
REQ-014 SHALL have port imem_rsp_inst, input, INST_WIDTH, response instruction.
REQ-015 SHALL have port out_valid, output, 1, instruction available to ID.
REQ-016 SHALL have port out_ready, input, 1, ID accepts (low = stall).
REQ-017 SHALL have port out_pc, output, INST_ADDR_WIDTH, PC of head instruction.
REQ-018 SHALL have port out_inst, output, INST_WIDTH, head instruction.

Function
REQ-019 SHALL hold fetch_pc; a request fires when imem_req_valid && imem_req_ready; fetch_pc then advances by PC_STEP (modulo 2^INST_ADDR_WIDTH, wraps silently).
REQ-020 SHALL allocate one queue entry at the tail on each fired request, storing the request PC with its filled bit cleared.
REQ-021 SHALL assert imem_req_valid iff (allocated entries + drop_cnt) < FQ_DEPTH and redirect_valid is low.
REQ-022 SHALL keep imem_req_addr stable while imem_req_valid is high and ready is low, unless a redirect occurs.
REQ-023 SHALL accept responses strictly in request order, with earliest response one cycle after request acceptance.
REQ-024 SHALL discard a response, decrementing drop_cnt, when drop_cnt > 0; otherwise it SHALL write imem_rsp_inst into the oldest unfilled entry and set its filled bit.
REQ-025 SHALL ignore a response when no entry is pending and drop_cnt = 0.
REQ-026 SHALL drive out_valid = head entry filled and out_pc/out_inst from the head entry.
REQ-027 SHALL pop the head on out_valid && out_ready; pop and allocate in one cycle SHALL both take effect.
REQ-028 SHALL hold out_valid/out_pc/out_inst unchanged while out_ready is low.
REQ-029 SHALL, on redirect_valid, force out_valid low that cycle, ignore out_ready, flush all entries, and load fetch_pc = redirect_pc.
REQ-030 SHALL set drop_cnt_next = drop_cnt + unfilled allocated entries - (imem_rsp_valid ? 1 : 0) on redirect; a response in the redirect cycle counts as stale.
REQ-031 SHALL allow new requests from the cycle after redirect while drop_cnt > 0, subject to REQ-021.
REQ-032 SHALL let the later redirect win on back-to-back redirects, accumulating drop_cnt per REQ-030.
REQ-033 SHALL have single-cycle latency from a response to out_valid, i.e. no combinational response-to-output path.

Reset
REQ-034 SHALL, while cpu_rst_n is low, asynchronously set fetch_pc = RESET_PC, queue pointers and occupancy to 0, all filled bits to 0, drop_cnt = 0, out_valid = 0, imem_req_valid = 0.
REQ-035 SHALL discard any response arriving during reset and SHALL NOT require a prior redirect after reset.
REQ-036 SHALL issue the first request, addr = RESET_PC, in the first cycle after cpu_rst_n deasserts.

Verification
REQ-037 SHALL cover streaming: ready=1, 1-cycle responses, out_ready=1 -> out_pc sequence 0x0,0x4,0x8,... one per cycle after a 2-cycle fill.
REQ-038 SHALL cover back-pressure: out_ready=0 with 4 responses returned -> imem_req_valid low after 4 requests, out_pc stays 0x0, no request lost.
REQ-039 SHALL cover redirect with 3 in flight: redirect_pc=0x100 -> 3 responses dropped, next out_pc=0x100, drop_cnt returns to 0.
REQ-040 SHALL cover a simultaneous redirect and response: stale response not delivered, drop_cnt = pending-1.
REQ-041 SHALL cover wrap-around: fetch_pc=0xFFFFFFFC -> next request addr 0x0.
REQ-042 SHALL cover reset asserted mid-stream with 2 entries filled -> out_valid=0 immediately, after release first request addr = RESET_PC.
